// File: rtl/rv32_pkg.sv
// Shared RV32 core types: LSU operation encoding, LSU FSM states and op classification helpers.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        OpNone = 4'd0,
        OpLb   = 4'd1,
        OpLh   = 4'd2,
        OpLw   = 4'd3,
        OpLbu  = 4'd4,
        OpLhu  = 4'd5,
        OpSb   = 4'd6,
        OpSh   = 4'd7,
        OpSw   = 4'd8
    } lsu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input lsu_op_t op);
        return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        return op inside {OpSb, OpSh, OpSw};
    endfunction

    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] offset);
        logic half_op;
        logic word_op;
        half_op = op inside {OpLh, OpLhu, OpSh};
        word_op = op inside {OpLw, OpSw};
        return (half_op && offset[0]) || (word_op && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or zero-extends it.
module lsu_load_align
    import rv32_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  lsu_op_t               op_i,
    input  logic [1:0]            offset_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
        case (op_i)
            OpLb:    data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            OpLbu:   data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            OpLh:    data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            OpLhu:   data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access, NONE pass-through and misalignment trap.
module lsu
    import rv32_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  lsu_op_t               mem_op_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [4:0]            rd_i,
    output logic                  ready_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            wb_rd_o,
    output logic                  misalign_o
);

    lsu_state_t            state_q;
    lsu_op_t               op_q;
    logic [1:0]            off_q;
    logic [4:0]            rd_q;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] load_data;

    // Lane steering for the incoming op; loads request the full word.
    always_comb begin
        case (mem_op_i)
            OpSb: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {(DATA_WIDTH/8){store_data_i[7:0]}};
            end
            OpSh: begin
                be_new    = 4'b0011 << addr_i[1:0];
                wdata_new = {(DATA_WIDTH/16){store_data_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data_i;
            end
        endcase
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .op_i    (op_q),
        .offset_i(off_q),
        .rdata_i (dmem_rdata_i),
        .data_o  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            ready_o      <= 1'b1;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            wb_rd_o      <= '0;
            misalign_o   <= 1'b0;
            op_q         <= OpNone;
            off_q        <= '0;
            rd_q         <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid_i && ready_o) begin
                        if (!is_load(mem_op_i) && !is_store(mem_op_i)) begin
                            wb_valid_o <= 1'b1;
                            wb_data_o  <= addr_i;
                            wb_rd_o    <= rd_i;
                        end else if (is_misaligned(mem_op_i, addr_i[1:0])) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state_q      <= StReq;
                            ready_o      <= 1'b0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= is_store(mem_op_i);
                            dmem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            dmem_be_o    <= be_new;
                            dmem_wdata_o <= wdata_new;
                            op_q         <= mem_op_i;
                            off_q        <= addr_i[1:0];
                            rd_q         <= rd_i;
                        end
                    end
                end
                StReq: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (is_store(op_q)) begin
                            state_q <= StIdle;
                            ready_o <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (dmem_rvalid_i) begin
                        state_q    <= StIdle;
                        ready_o    <= 1'b1;
                        wb_valid_o <= 1'b1;
                        wb_data_o  <= load_data;
                        wb_rd_o    <= rd_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus random traffic against a word-memory model.
module tb_lsu;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    lsu_op_t     mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        ready_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        misalign_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [16];

    lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .rd_i         (rd_i),
        .ready_o      (ready_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_data_o    (wb_data_o),
        .wb_rd_o      (wb_rd_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'd15);
    endfunction

    // Garbage on the upstream inputs while the unit is busy must have no effect.
    task automatic scramble();
        valid_i      = 1'($urandom_range(0, 1));
        mem_op_i     = lsu_op_t'($urandom_range(0, 8));
        addr_i       = $urandom;
        store_data_i = $urandom;
        rd_i         = 5'($urandom);
    endtask

    task automatic do_op(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input int gd, input int rvd);
        int          off;
        bit          ld, st, mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, word, sh, exp_ld;
        off = int'(addr[1:0]);
        ld  = op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
        st  = op inside {OpSb, OpSh, OpSw};
        mis = ((op inside {OpLh, OpLhu, OpSh}) && (off % 2 != 0)) ||
              ((op inside {OpLw, OpSw}) && off != 0);
        if (op == OpSb) begin
            exp_be = 4'(1 << off);
            exp_wd = (sd & 32'hFF) * 32'h01010101;
        end else if (op == OpSh) begin
            exp_be = 4'(3 << off);
            exp_wd = (sd & 32'hFFFF) * 32'h00010001;
        end else begin
            exp_be = 4'hF;
            exp_wd = sd;
        end

        check("ready_before_accept", ready_o, 1'b1);
        valid_i = 1'b1; mem_op_i = op; addr_i = addr; store_data_i = sd; rd_i = rd;
        @(negedge clk);
        if (!ld && !st) begin
            valid_i = 1'b0;
            check("none_wb_valid", wb_valid_o, 1'b1);
            check("none_wb_data", wb_data_o, addr);
            check("none_wb_rd", wb_rd_o, rd);
            check("none_no_req", dmem_req_o, 1'b0);
            check("none_ready", ready_o, 1'b1);
        end else if (mis) begin
            valid_i = 1'b0;
            check("mis_pulse", misalign_o, 1'b1);
            check("mis_no_req", dmem_req_o, 1'b0);
            check("mis_no_wb", wb_valid_o, 1'b0);
            check("mis_ready", ready_o, 1'b1);
        end else begin
            check("req_high", dmem_req_o, 1'b1);
            check("req_we", dmem_we_o, st);
            check("req_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
            check("req_be", dmem_be_o, exp_be);
            if (st) check("req_wdata", dmem_wdata_o, exp_wd);
            check("req_busy", ready_o, 1'b0);
            for (int i = 0; i < gd; i++) begin
                scramble();
                dmem_gnt_i = 1'b0;
                @(negedge clk);
                check("req_held", dmem_req_o, 1'b1);
                check("req_addr_held", dmem_addr_o, addr & 32'hFFFF_FFFC);
                check("req_be_held", dmem_be_o, exp_be);
            end
            scramble();
            dmem_gnt_i = 1'b1;
            @(negedge clk);
            dmem_gnt_i = 1'b0;
            check("req_dropped", dmem_req_o, 1'b0);
            if (st) begin
                valid_i = 1'b0;
                for (int b = 0; b < 4; b++)
                    if (exp_be[b]) mem[widx(addr)][b*8 +: 8] = exp_wd[b*8 +: 8];
                check("store_done_ready", ready_o, 1'b1);
                check("store_no_wb", wb_valid_o, 1'b0);
            end else begin
                check("load_wait_busy", ready_o, 1'b0);
                for (int i = 0; i < rvd; i++) begin
                    scramble();
                    dmem_rvalid_i = 1'b0;
                    dmem_rdata_i  = $urandom;
                    @(negedge clk);
                    check("load_wait_no_wb", wb_valid_o, 1'b0);
                end
                scramble();
                word = mem[widx(addr)];
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = word;
                @(negedge clk);
                dmem_rvalid_i = 1'b0;
                valid_i       = 1'b0;
                sh = word >> (8 * off);
                case (op)
                    OpLb:    exp_ld = {{24{sh[7]}}, sh[7:0]};
                    OpLbu:   exp_ld = {24'h0, sh[7:0]};
                    OpLh:    exp_ld = {{16{sh[15]}}, sh[15:0]};
                    OpLhu:   exp_ld = {16'h0, sh[15:0]};
                    default: exp_ld = word;
                endcase
                check("load_wb_valid", wb_valid_o, 1'b1);
                check("load_wb_data", wb_data_o, exp_ld);
                check("load_wb_rd", wb_rd_o, rd);
                check("load_done_ready", ready_o, 1'b1);
            end
        end
        @(negedge clk);
        check("wb_pulse_end", wb_valid_o, 1'b0);
        check("mis_pulse_end", misalign_o, 1'b0);
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; mem_op_i = OpNone; addr_i = '0; store_data_i = '0;
        rd_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 1'b1);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_we", dmem_we_o, 1'b0);
        check("rst_be", dmem_be_o, 4'h0);
        check("rst_addr", dmem_addr_o, 32'h0);
        check("rst_wdata", dmem_wdata_o, 32'h0);
        check("rst_wb_valid", wb_valid_o, 1'b0);
        check("rst_wb_data", wb_data_o, 32'h0);
        check("rst_wb_rd", wb_rd_o, 5'd0);
        check("rst_misalign", misalign_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Directed scenarios
        do_op(OpSw, 32'h100, 32'hDEADBEEF, 5'd3, 2, 0);
        check("sw_mem", mem[widx(32'h100)], 32'hDEADBEEF);
        mem[widx(32'h203)] = 32'h80FFFFFF;
        do_op(OpLb, 32'h203, 32'h0, 5'd4, 0, 0);
        check("lb_sign", wb_data_o, 32'hFFFFFF80);
        do_op(OpLbu, 32'h203, 32'h0, 5'd5, 1, 2);
        check("lbu_zero", wb_data_o, 32'h00000080);
        do_op(OpSh, 32'h302, 32'h1234ABCD, 5'd6, 0, 0);
        check("sh_be", dmem_be_o, 4'b1100);
        check("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
        do_op(OpLw, 32'h102, 32'h0, 5'd8, 0, 0);
        do_op(OpNone, 32'h55, 32'h0, 5'd7, 0, 0);
        check("none_hold_data", wb_data_o, 32'h55);
        check("none_hold_rd", wb_rd_o, 5'd7);
        do_op(OpLw, 32'h104, 32'h0, 5'd0, 0, 0);

        // Reset while waiting for read data abandons the load
        valid_i = 1'b1; mem_op_i = OpLw; addr_i = 32'h400; rd_i = 5'd9;
        @(negedge clk);
        valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        check("rstwait_busy", ready_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstwait_ready", ready_o, 1'b1);
        check("rstwait_req", dmem_req_o, 1'b0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        check("rstwait_no_wb", wb_valid_o, 1'b0);
        check("rstwait_idle", ready_o, 1'b1);
        check("rstwait_req2", dmem_req_o, 1'b0);

        // Random traffic over a 64-byte window
        for (int n = 0; n < 250; n++) begin
            do_op(lsu_op_t'($urandom_range(0, 8)), 32'h1000 + $urandom_range(0, 63),
                  $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (from rv32_pkg): datapath width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: data-memory address width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 valid_i  input  1  execute result valid this cycle.
REQ-006 mem_op_i  input  lsu_op_t  NONE/LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-007 addr_i  input  DATA_WIDTH  execute alu_res_o: effective address, or the ALU result for NONE.
REQ-008 store_data_i  input  DATA_WIDTH  rs2 data for stores.
REQ-009 rd_i  input  5  destination register.
REQ-010 ready_o  output  1  stage can accept; high only in IDLE.
REQ-011 dmem_req_o, dmem_we_o  output  1 each  memory request, write enable.
REQ-012 dmem_addr_o  output  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
REQ-013 dmem_be_o  output  4  byte enables; dmem_wdata_o  output  DATA_WIDTH  lane-aligned store data.
REQ-014 dmem_gnt_i, dmem_rvalid_i  input  1 each  request accepted, read data valid; dmem_rdata_i  input  DATA_WIDTH.
REQ-015 wb_valid_o  output  1; wb_data_o  output  DATA_WIDTH; wb_rd_o  output  5  writeback bundle.
REQ-016 misalign_o  output  1  one-cycle misaligned-access exception pulse.

Function
REQ-017 FSM states IDLE, REQ, WAIT; transfer accepted when valid_i && ready_o.
REQ-018 Accepted op, address, store data and rd SHALL be registered on accept; later input changes have no effect.
REQ-019 NONE accepted: stay IDLE; next cycle wb_valid_o=1, wb_data_o=addr_i, wb_rd_o=rd_i (1-cycle pass-through).
REQ-020 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; then no memory request, stay IDLE, misalign_o=1 next cycle, no wb_valid_o.
REQ-021 Aligned load/store accepted: IDLE->REQ; dmem_req_o=1 and address/be/wdata/we held stable in REQ until dmem_gnt_i.
REQ-022 REQ with gnt: store -> IDLE (no writeback); load -> WAIT.
REQ-023 dmem_rvalid_i SHALL be sampled only in WAIT; on rvalid -> IDLE, and next cycle wb_valid_o=1 with extracted data and the registered rd.
REQ-024 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b1111 with dmem_we_o=0.
REQ-025 Store data: SB byte replicated on all 4 lanes; SH halfword replicated on both halves; SW unchanged.
REQ-026 Load extraction: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-027 wb_valid_o and misalign_o SHALL be single-cycle pulses; wb_data_o/wb_rd_o hold their last value otherwise.
REQ-028 Loads to rd=0 SHALL complete normally; register-file suppression is downstream.
REQ-029 valid_i while ready_o=0 SHALL be ignored; upstream stalls on ready_o.
REQ-030 Minimum throughput: store 2 cycles, load 3 cycles with zero-wait memory.

Reset
REQ-031 rst=0 SHALL force IDLE and ready_o=1; dmem_req_o, dmem_we_o, wb_valid_o, misalign_o=0; dmem_be_o=0; dmem_addr_o, dmem_wdata_o, wb_data_o=0; wb_rd_o=0.
REQ-032 Reset in REQ/WAIT SHALL abandon the access; a stray dmem_rvalid_i after reset SHALL be ignored.

Structure
REQ-033 lsu_op_t (4-bit enum) and LSU state enum SHALL live in rv32_pkg.
REQ-034 Load extraction/extension SHALL be a combinational sub-module lsu_load_align.

Verification
REQ-035 SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> be=1111, addr 0x100, req held 3 cycles, no wb_valid_o.
REQ-036 LB addr 0x203, rdata 0x80FFFFFF -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x302, data 0x1234ABCD -> be=1100, wdata=0xABCDABCD.
REQ-038 LW addr 0x102 -> misalign_o pulse, dmem_req_o never high, ready_o stays 1.
REQ-039 NONE addr_i=0x55, rd=7 -> next cycle wb_valid_o=1, wb_data_o=0x55, wb_rd_o=7.
REQ-040 LW in WAIT, rst=0 one cycle, then rvalid -> IDLE, no wb_valid_o.
